// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       xreset,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  logic        rxd_meta_q;
  logic        rxd_sync_q;
  logic        rxd_prev_q;
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q;
  logic        push;
  logic        push_ok;
  logic        pop;

  // rxd_prev_q follows the synchronized line so IDLE can see a 1->0 edge.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Edge-triggered start: a held-low break cannot retrigger until the line goes high.
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rxd_sync_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (timer_q == BIT_M1) begin
          timer_d   = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (timer_q == BIT_M1) begin
          timer_d = '0;
          state_d = IDLE;
          if (rxd_sync_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full;

  assign rvalid  = (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign full    = (count_q == DEPTH_C);
  assign pop     = rvalid && rready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;
  logic       unused_depth;

  // FIFO_DEPTH has no role in holding-register mode.
  assign unused_depth = ^(32'(FIFO_DEPTH));

  assign rvalid  = hold_vld_q;
  assign rdata   = hold_q;
  assign pop     = hold_vld_q && rready;
  assign push_ok = push && (!hold_vld_q || pop);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (push_ok) begin
        hold_q     <= shift_q;
        hold_vld_q <= 1'b1;
      end else if (pop) begin
        hold_vld_q <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      overrun_q <= 1'b0;
    end else if (push && !push_ok) begin
      overrun_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the receive buffer depth; power of two, 2..64; used only when UART_RX_FIFO_EN is defined.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port xreset, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rxd, input, 1, serial line, idle high; asynchronous to clk.
REQ-006 SHALL have port rdata, output, u8_t, received byte at buffer head.
REQ-007 SHALL have port rvalid, output, 1, rdata holds an unread byte.
REQ-008 SHALL have port rready, input, 1, consumer accepts rdata.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1, sticky flag set when a received byte is dropped.
REQ-011 SHALL have port busy, output, 1, high while a frame is being received (state not IDLE).

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; both flops reset to 1; all sampling uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP with a 16-bit bit-timer and a 3-bit bit index.
REQ-014 IDLE: a synchronized 1->0 transition SHALL enter START with the timer cleared.
REQ-015 START: at timer = CLKS_PER_BIT/2-1, line 0 -> DATA with timer cleared; line 1 (glitch) -> IDLE with nothing pushed.
REQ-016 DATA: at each timer = CLKS_PER_BIT-1, SHALL sample one bit LSB first into a shift register; after bit 7 -> STOP.
REQ-017 STOP: at timer = CLKS_PER_BIT-1, line 1 -> push byte and go IDLE; line 0 -> frame_err high for exactly one cycle, byte discarded, go IDLE.
REQ-018 A break (line held low) SHALL NOT start a new frame until the line has returned to 1.
REQ-019 Push latency: rvalid SHALL be high on the cycle after the stop-bit sample when the buffer was empty.
REQ-020 A transfer SHALL occur on each rising clk edge with rvalid && rready; rdata SHALL stay stable while rvalid && !rready.
REQ-021 A push into a full buffer SHALL drop the new byte and set overrun; the buffer contents SHALL be unchanged.
REQ-022 A simultaneous pop and push on a full buffer SHALL accept the new byte without setting overrun.
REQ-023 overrun SHALL clear only on reset.

Reset
REQ-024 On xreset low: state IDLE, timer/index/shift 0, buffer empty, rvalid 0, rdata 0x00, frame_err 0, overrun 0, busy 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no push; after release the next falling edge SHALL start a fresh frame.

Configuration
REQ-026 Macro UART_RX_FIFO_EN defined: the buffer SHALL be a FIFO_DEPTH-entry FIFO with wrapping read/write pointers and an occupancy count; bytes SHALL emerge in arrival order.
REQ-027 Macro UART_RX_FIFO_EN undefined: the buffer SHALL be a single holding register; full means rvalid=1; FIFO_DEPTH SHALL be ignored.

Verification (CLKS_PER_BIT=8)
REQ-028 Frame 0x55 with rready=1 -> rvalid pulse with rdata=0x55 one cycle after the stop sample; frame_err=0, overrun=0.
REQ-029 rxd low for 2 cycles, then high -> returns to IDLE; no rvalid, no frame_err.
REQ-030 Frame 0xA3 with stop bit 0 -> frame_err high for exactly one cycle; rvalid stays 0.
REQ-031 With UART_RX_FIFO_EN, 9 frames 0x00..0x08 with rready=0, then drain -> reads 0x00..0x07 in order; overrun=1. Without UART_RX_FIFO_EN, 2 frames -> reads 0x00 only; overrun=1.
REQ-032 Reset pulsed during bit 4 of a frame, then frame 0x3C -> exactly one byte, 0x3C; overrun=0.
REQ-033 Back-to-back frames 0x12, 0x34 with rready=1 and no idle gap -> both bytes received in order; no errors.
